c17_bist_ctrl: RTL

Built-in self-test controller for the c17 combinational block. It generates input patterns from a 5-bit LFSR and launches them from a register into c17 inputs N1, N2, N3, N6, N7. It compacts the N22/N23 responses into a 16-bit MISR and compares the final signature with a golden value. The controller supplies launch/capture flops around c17 so the path is timeable register-to-register.

---
 rtl/c17_bist_ctrl.sv | 136 +++++++++++++
 1 files changed

// File: rtl/c17_bist_ctrl.sv
// rtl/c17_bist_ctrl.sv - BIST controller: pattern launch, MISR compaction and golden compare for c17
// Build option: C17_BIST_EXHAUSTIVE_EN swaps the LFSR for a 5-bit binary up-counter starting at 0.
module c17_bist_ctrl #(
    parameter int         NUM_PATTERNS = 31,
    parameter logic [4:0] LFSR_SEED    = 5'h1F
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic [15:0] golden_sig,
    input  logic [1:0]  dut_out,
    output logic [4:0]  dut_in,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] signature,
    output logic [5:0]  pattern_cnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [5:0] LAST_IDX = 6'(NUM_PATTERNS - 1);

`ifdef C17_BIST_EXHAUSTIVE_EN
    localparam logic [4:0] FIRST_PAT = 5'h00;
`else
    // An all-zero seed would lock the LFSR, so it is promoted to 1.
    localparam logic [4:0] FIRST_PAT = (LFSR_SEED == 5'h00) ? 5'h01 : LFSR_SEED;
`endif

    state_t      state_q, state_d;
    logic [4:0]  pat_q, pat_d;
    logic [15:0] sig_q, sig_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        pass_q, pass_d;
    logic [15:0] sig_next;
    logic        last_pat;

    function automatic logic [4:0] next_pattern(input logic [4:0] q);
`ifdef C17_BIST_EXHAUSTIVE_EN
        return q + 5'd1;
`else
        return {q[3:0], q[4] ^ q[2]};
`endif
    endfunction

    function automatic logic [15:0] misr_step(input logic [15:0] s, input logic [1:0] d);
        return {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ {14'b0, d};
    endfunction

    assign sig_next = misr_step(sig_q, dut_out);
    assign last_pat = (cnt_q == LAST_IDX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: if (start) state_d = S_RUN;
                S_RUN:          if (last_pat) state_d = S_DONE;
                default:        state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        busy = (state_q == S_RUN);
        done = (state_q == S_DONE);
        pass = pass_q;
    end

    // Datapath: abort freezes signature and pattern but clears the verdict.
    always_comb begin
        pat_d  = pat_q;
        sig_d  = sig_q;
        cnt_d  = cnt_q;
        pass_d = pass_q;
        if (abort) begin
            pass_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        pat_d  = FIRST_PAT;
                        sig_d  = 16'h0000;
                        cnt_d  = 6'd0;
                        pass_d = 1'b0;
                    end
                end
                S_RUN: begin
                    sig_d = sig_next;
                    if (last_pat) begin
                        pass_d = (sig_next == golden_sig);
                    end else begin
                        cnt_d = cnt_q + 6'd1;
                        pat_d = next_pattern(pat_q);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pat_q  <= 5'h00;
            sig_q  <= 16'h0000;
            cnt_q  <= 6'd0;
            pass_q <= 1'b0;
        end else begin
            pat_q  <= pat_d;
            sig_q  <= sig_d;
            cnt_q  <= cnt_d;
            pass_q <= pass_d;
        end
    end

    assign dut_in      = pat_q;
    assign signature   = sig_q;
    assign pattern_cnt = cnt_q;

endmodule
